// File: rtl/mod_7seg_scan.sv
// Multi-digit 7-segment scanner: time-multiplexes a double-buffered hex value
// one digit per slot, with a blanking guard at the start of every slot.
module mod_7seg_scan #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  localparam int IDX_W       = $clog2(N_DIGITS),
  localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic [4*N_DIGITS-1:0]   i_value,
  input  logic                    i_load,
  input  logic [N_DIGITS-1:0]     i_blank_mask,
  output logic [3:0]              o_nibble,
  output logic [N_DIGITS-1:0]     o_anodes,
  output logic [IDX_W-1:0]        o_digit_idx,
  output logic                    o_frame_start
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [0:0]            state, state_nxt;
  logic [4*N_DIGITS-1:0] displayed, displayed_nxt;
  logic [4*N_DIGITS-1:0] pending;
  logic                  pending_valid;
  logic                  slot_end;
  logic                  commit;
  logic [N_DIGITS-1:0]   anodes_nxt;
  logic [3:0]            nibble_nxt;

  function automatic logic [3:0] digit_sel(input logic [4*N_DIGITS-1:0] v,
                                           input logic [IDX_W-1:0] k);
    logic [3:0] d;
    d = 4'h0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (k == IDX_W'(i)) d = v[4*i +: 4];
    end
    return d;
  endfunction

  always_comb begin
    slot_end = (cnt == CNT_LAST);
    commit   = slot_end && (idx == IDX_LAST);
    cnt_nxt  = slot_end ? '0 : cnt + CNT_W'(1);
    idx_nxt  = idx;
    if (slot_end) idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  end

  // A load landing on the commit cycle bypasses the pending buffer entirely.
  always_comb begin
    displayed_nxt = displayed;
    if (commit) begin
      if (i_load)             displayed_nxt = i_value;
      else if (pending_valid) displayed_nxt = pending;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BLANK: if (cnt_nxt == BLANK_END) state_nxt = ST_DRIVE;
      ST_DRIVE: if (slot_end)             state_nxt = ST_BLANK;
      default:                            state_nxt = ST_BLANK;
    endcase
  end

  // Outputs are computed from next-cycle state so the registered values line
  // up with cnt/idx; the mask is applied live without buffering.
  always_comb begin
    anodes_nxt = '1;
    if (state_nxt == ST_DRIVE && !i_blank_mask[idx_nxt]) anodes_nxt[idx_nxt] = 1'b0;
    nibble_nxt = slot_end ? digit_sel(displayed_nxt, idx_nxt) : o_nibble;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt           <= '0;
      idx           <= '0;
      state         <= ST_BLANK;
      displayed     <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      o_nibble      <= 4'h0;
      o_anodes      <= '1;
      o_digit_idx   <= '0;
      o_frame_start <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      state     <= state_nxt;
      displayed <= displayed_nxt;
      if (commit) begin
        pending_valid <= 1'b0;
      end else if (i_load) begin
        pending       <= i_value;
        pending_valid <= 1'b1;
      end
      o_nibble      <= nibble_nxt;
      o_anodes      <= anodes_nxt;
      o_digit_idx   <= idx_nxt;
      o_frame_start <= commit;
    end
  end

endmodule

// File: tb/tb_mod_7seg_scan.sv
// Bench for mod_7seg_scan: cycle-count reference model plus directed literal checks.
module tb_mod_7seg_scan;
  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int F = N * R;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  mask = '0;
  logic [3:0]  nibble;
  logic [3:0]  anodes;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model: time since reset release plus the buffered values.
  int          cyc;
  logic [15:0] disp, pend;
  bit          pv;
  logic [3:0]  m_nib, m_mask;
  bit          m_fs;

  mod_7seg_scan #(.N_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_value(value), .i_load(load),
    .i_blank_mask(mask), .o_nibble(nibble), .o_anodes(anodes),
    .o_digit_idx(digit_idx), .o_frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; disp = '0; pend = '0; pv = 0;
    m_nib = 4'h0; m_fs = 0; m_mask = 4'h0;
  endtask

  task automatic model_step();
    logic [15:0] sh;
    bit wrap;
    if (!nrst) begin
      model_reset();
    end else begin
      cyc++;
      wrap = (cyc % F == 0);
      if (wrap) begin
        if (load) begin disp = value; pv = 0; end
        else if (pv) begin disp = pend; pv = 0; end
      end else if (load) begin
        pend = value; pv = 1;
      end
      m_fs = wrap;
      if (cyc % R == 0) begin
        sh = disp >> (4 * ((cyc / R) % N));
        m_nib = sh[3:0];
      end
      m_mask = mask;
    end
  endtask

  task automatic compare();
    int c, k;
    logic [3:0] exp_an;
    c = cyc % R;
    k = (cyc / R) % N;
    exp_an = 4'hF;
    if (c >= B && !m_mask[k]) exp_an[k] = 1'b0;
    chk("anodes", 32'(anodes), 32'(exp_an));
    chk("nibble", 32'(nibble), 32'(m_nib));
    chk("digit_idx", 32'(digit_idx), 32'(k));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("one_low", 32'($countones(~anodes) <= 1), 32'd1);
    if (c < B) chk("guard", 32'(anodes), 32'hF);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic tick_to(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < 2000) begin
      tick();
      guard++;
    end
    if (cyc != target) chk("tick_to_bound", 32'(cyc), 32'(target));
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset held
    repeat (3) tick();
    chk("rst_anodes", 32'(anodes), 32'hF);
    chk("rst_nibble", 32'(nibble), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    nrst = 1'b1;

    // Power-up scan with zero value
    tick_to(1);  chk("s0_c1", 32'(anodes), 32'hF);
    tick_to(2);  chk("s0_c2", 32'(anodes), 32'b1110);
    tick_to(7);  chk("s0_c7", 32'(anodes), 32'b1110);
    tick_to(9);  chk("s1_c1", 32'(anodes), 32'hF);
    chk("s1_idx", 32'(digit_idx), 32'd1);
    tick_to(10); chk("s1_c2", 32'(anodes), 32'b1101);

    // Frame commit: load at cycle 5 of digit 1
    tick_to(13);
    pulse_load(16'hA3C5);
    tick_to(24); chk("pre_commit", 32'(nibble), 32'h0);
    tick_to(32); chk("c_d0", 32'(nibble), 32'h5); chk("c_fs", 32'(frame_start), 32'd1);
    tick_to(33); chk("c_fs_off", 32'(frame_start), 32'd0);
    tick_to(40); chk("c_d1", 32'(nibble), 32'hC);
    tick_to(48); chk("c_d2", 32'(nibble), 32'h3);
    tick_to(56); chk("c_d3", 32'(nibble), 32'hA);
    tick_to(64); chk("c_fs2", 32'(frame_start), 32'd1);

    // Overwrite: last write wins
    tick_to(66); pulse_load(16'h1111);
    tick_to(70); pulse_load(16'h2222);
    tick_to(96);  chk("ow_d0", 32'(nibble), 32'h2);
    tick_to(120); chk("ow_d3", 32'(nibble), 32'h2);

    // Load coinciding with the wrap cycle
    tick_to(127); pulse_load(16'h7777);
    chk("co_d0", 32'(nibble), 32'h7);
    tick_to(160); chk("co_next", 32'(nibble), 32'h7);

    // Leading-digit blanking
    tick_to(161); mask = 4'b1100; pulse_load(16'h0042);
    tick_to(194); chk("bl_d0", 32'(anodes), 32'b1110); chk("bl_n0", 32'(nibble), 32'h2);
    tick_to(202); chk("bl_d1", 32'(anodes), 32'b1101); chk("bl_n1", 32'(nibble), 32'h4);
    tick_to(212); chk("bl_d2", 32'(anodes), 32'hF);
    tick_to(220); chk("bl_d3", 32'(anodes), 32'hF);
    tick_to(224); chk("bl_fs", 32'(frame_start), 32'd1);
    mask = 4'b0000;

    // Mid-operation reset during DRIVE of digit 2, with data pending
    tick_to(230); pulse_load(16'h9999);
    tick_to(243);
    chk("pre_rst_drive", 32'(anodes), 32'b1011);
    #1 nrst = 1'b0;
    #1;
    model_reset();
    chk("mr_anodes", 32'(anodes), 32'hF);
    chk("mr_nibble", 32'(nibble), 32'h0);
    chk("mr_idx", 32'(digit_idx), 32'h0);
    chk("mr_fs", 32'(frame_start), 32'h0);
    repeat (2) tick();
    nrst = 1'b1;
    tick_to(2);  chk("mr_c2", 32'(anodes), 32'b1110);
    tick_to(32); chk("mr_discard", 32'(nibble), 32'h0);

    // Random loads and mask changes over 10 frames
    for (int i = 0; i < 10 * F; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      tick();
    end
    load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mod_7seg_scan.md
Name: mod_7seg_scan

Overview:
- Multi-digit display scanner; sits directly upstream of the per-digit 7-segment decoder.
- Holds an N-digit hex value and time-multiplexes it one digit at a time.
  - o_nibble drives the decoder's i_value.
  - o_anodes drives the active-low digit commons.
- Inserts a blanking guard at the start of each digit slot. The guard absorbs the decoder's one-cycle registered latency and suppresses ghosting.
- New values are double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
- N_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be at least 4.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off; legal range 1 to REFRESH_DIV-2.

Ports:
- i_clk  input  1  system clock.
- i_nrst  input  1  asynchronous active-low reset.
- i_value  input  4*N_DIGITS  value to display; digit k is bits [4k+3:4k]; digit 0 is least significant.
- i_load  input  1  single-cycle strobe that captures i_value into the pending buffer.
- i_blank_mask  input  N_DIGITS  bit k=1 keeps digit k's anode off (leading-zero suppression); sampled live.
- o_nibble  output  4  current digit nibble, to the decoder.
- o_anodes  output  N_DIGITS  active-low digit enables; at most one bit is low at any time.
- o_digit_idx  output  $clog2(N_DIGITS)  index of the current slot.
- o_frame_start  output  1  one-cycle pulse in the first cycle of digit-0 slot.

Behaviour:
- Clock and reset: single clock domain, i_clk; reset is asynchronous and active-low on i_nrst.
- All outputs are registered. o_nibble, o_anodes, o_digit_idx and o_frame_start are mutually consistent in every cycle.
- Reset (asynchronous, also mid-operation), effective immediately:
  - displayed=0, pending=0, pending_valid=0
  - slot counter cnt=0, idx=0, state=BLANK
  - o_anodes all 1, o_nibble=0, o_digit_idx=0, o_frame_start=0
- First cycle after reset release:
  - cnt=0, idx=0, BLANK.
  - o_frame_start does not pulse for this first frame; it pulses at every subsequent wrap to idx 0.
- Slot counter: cnt counts 0..REFRESH_DIV-1. At cnt=REFRESH_DIV-1 the next cycle has cnt=0 and idx=idx+1, wrapping N_DIGITS-1 -> 0.
- Frame period is exactly N_DIGITS*REFRESH_DIV cycles.
- FSM per slot:
  - BLANK (cnt < BLANK_CYCLES): o_anodes all 1.
  - DRIVE (cnt >= BLANK_CYCLES): o_anodes[idx]=0 unless i_blank_mask[idx]=1; all other bits 1.
  - Transitions: BLANK -> DRIVE when cnt reaches BLANK_CYCLES; DRIVE -> BLANK at slot wrap.
- o_nibble = displayed digit idx; it is updated in the first cycle of every slot and held for the whole slot.
  - Because BLANK_CYCLES >= 1, the decoder output is valid before any anode asserts.
- Load and commit:
  - i_load=1: pending <= i_value, pending_valid <= 1. A later i_load before commit overwrites pending (last write wins).
  - Commit occurs on the cycle that wraps idx to 0: displayed <= pending, pending_valid <= 0.
  - Digit 0 of the new frame already shows the committed value.
  - If i_load coincides with the commit cycle, i_value is committed directly and pending_valid stays 0.
  - With no pending data at the wrap, displayed is unchanged.
- i_blank_mask changes take effect on the next cycle's anodes, mid-slot if necessary. No buffering.

Test Plan:
All scenarios use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset check: hold i_nrst=0 -> o_anodes=4'b1111, o_nibble=0, o_digit_idx=0. Release, no load -> every slot drives nibble 0.
  - Slot 0: anodes 1111 for cycles 0-1, then 1110 for cycles 2-7.
  - Slot 1 then starts with o_digit_idx=1 and anodes 1101 from its cycle 2.
- Frame commit: pulse i_load with i_value=16'hA3C5 at cycle 5 of digit 1 -> digits 1-3 still show 0. From the next digit-0 slot, o_nibble sequence is 5, C, 3, A with o_frame_start pulsing once every 32 cycles.
- Overwrite and coincidence:
  - Load 16'h1111 then 16'h2222 within one frame -> only 2s are shown.
  - Load 16'h7777 exactly on the idx 3 -> 0 wrap cycle -> digit 0 of that frame shows 7; pending_valid=0 afterwards.
- Blanking: i_blank_mask=4'b1100 with value 16'h0042 -> anodes low only for digits 0 and 1. Digits 2-3 slots keep 1111 for all 8 cycles; frame timing is unchanged.
- Mid-operation reset: assert i_nrst=0 during the DRIVE phase of digit 2 -> the same delta sees anodes 1111, displayed=0 and pending discarded. After release, the scan restarts from idx 0, cnt 0.
- Invariant checks over 10 random frames with random loads:
  - At most one o_anodes bit is low at any time.
  - No anode is low in cycles 0-1 of any slot.
  - o_nibble is stable throughout each slot.
